key_event_arbiter: RTL
======================

KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 SHALL have port CLOCK_50  input  1  board clock; all logic on its rising edge.
REQ-002 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-003 SHALL have port CODE_IN  input  8  received PS/2 data byte.
REQ-004 SHALL have port CODE_VALID  input  1  one-cycle strobe qualifying CODE_IN.
REQ-005 SHALL have port CODE_ERR  input  1  framing/parity error flag, sampled with CODE_VALID.
REQ-006 SHALL have port KEYS_HELD  output  17  held-key bitmap, bit n = key index n.
REQ-007 SHALL have port EVT_VALID  output  1  event available on EVT_* outputs.
REQ-008 SHALL have port EVT_READY  input  1  consumer accepts event.
REQ-009 SHALL have port EVT_PLAYER  output  1  0 = player 1, 1 = player 2.
REQ-010 SHALL have port EVT_KEY  output  5  key index of the event.
REQ-011 SHALL have port EVT_MAKE  output  1  1 = press, 0 = release.
REQ-012 SHALL have port SPACE_PULSE  output  1  one-cycle strobe on a fresh SPACE press.
REQ-013 SHALL have port OVERFLOW  output  1  sticky flag: an event was dropped.

Function
REQ-014 Key indices SHALL be: 0-3 = E0-prefixed 75/72/6B/74 (up/down/left/right); 4-7 = 1D/1C/1B/23 (W/A/S/D); 8-11 = 35/34/33/3B (Y/G/H/J); 12-15 = 4D/4B/4C/52 (P/L/;/'); 16 = 29 (SPACE).
REQ-015 Arrow codes without E0 SHALL be ignored; E0 followed by a non-arrow code SHALL be ignored.
REQ-016 The parser FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
REQ-017 Transitions: IDLE-E0->EXT; IDLE-F0->BRK; EXT-F0->EXT_BRK; any other byte SHALL be decoded as make (IDLE/EXT) or break (BRK/EXT_BRK), then the FSM returns to IDLE.
REQ-018 A byte with CODE_ERR=1 SHALL be discarded and force the FSM to IDLE.
REQ-019 Unmapped codes SHALL return the FSM to IDLE with no event.
REQ-020 A make SHALL set the KEYS_HELD bit; a break SHALL clear it; both SHALL be visible the cycle after CODE_VALID.
REQ-021 A make for an already-held key (typematic repeat) and a break for a non-held key SHALL produce no event.
REQ-022 Qualifying events SHALL be queued: indices 4-11 into FIFO P1, indices 0-3 and 12-15 into FIFO P2; each entry is {key[4:0], make}, depth 4.
REQ-023 SPACE SHALL not be queued; a fresh SPACE make SHALL assert SPACE_PULSE for one cycle, one cycle after CODE_VALID.
REQ-024 A write to a full FIFO SHALL drop the new event and set OVERFLOW; KEYS_HELD SHALL still update.
REQ-025 A write and a pop of the same full FIFO in the same cycle SHALL accept the write.
REQ-026 EVT_VALID SHALL be high whenever either FIFO is non-empty; EVT_* SHALL be driven from the granted FIFO head; an enqueued event SHALL be visible the cycle after the write edge.
REQ-027 A transfer occurs when EVT_VALID and EVT_READY are both high; the granted FIFO SHALL pop on that edge.
REQ-028 When both FIFOs are non-empty, the grant SHALL go to the player not granted in the last transfer (round-robin); otherwise it goes to the only non-empty FIFO.
REQ-029 While EVT_VALID=1 and EVT_READY=0, the grant and the EVT_* values SHALL remain stable.

Reset
REQ-030 RESET SHALL force: FSM IDLE, KEYS_HELD=0, both FIFOs empty, EVT_VALID=0, EVT_PLAYER/EVT_KEY/EVT_MAKE=0, SPACE_PULSE=0, OVERFLOW=0, last-grant=player 2 (so player 1 wins the first tie).
REQ-031 RESET asserted mid-prefix (in EXT, BRK or EXT_BRK) SHALL cause the next byte to be parsed from IDLE.
REQ-032 CODE_VALID during RESET SHALL be ignored.

Structure
REQ-033 Package key_codes_pkg SHALL hold the scan-code constants (E0, F0, 17 key codes), the key-index constants, the FSM state enum, and FIFO_DEPTH=4.
REQ-034 Each FIFO SHALL be an instance of sub-module key_evt_fifo (6-bit wide, depth 4, push/pop/full/empty).

Verification
REQ-035 Bytes 1D then F0 1D, EVT_READY=1 -> KEYS_HELD[4] rises then falls; events {P1,4,1} then {P1,4,0}.
REQ-036 Bytes E0 75, 75 (no prefix), E0 F0 75 -> only {P2,0,1} and {P2,0,0}; bit 0 set then cleared.
REQ-037 EVT_READY=0; 5 presses W,A,S,D,Y -> 4 queued events, OVERFLOW=1, KEYS_HELD[8]=1.
REQ-038 P1 and P2 FIFOs each hold 2 events, EVT_READY=1 -> output order P1,P2,P1,P2.
REQ-039 29 twice, then F0 29 -> exactly one SPACE_PULSE; no EVT_VALID.
REQ-040 E0 sent with CODE_ERR=1, then 75 -> no event (unmapped without prefix); RESET after F0, then 1C -> make event {P1,5,1}.

Source files
------------

// File: rtl/key_codes_pkg.sv
// PS/2 scan-code constants, key-index map and parser state encoding.
// Shared by the key event arbiter and its FIFO.
// decode_key() maps a data byte (plus E0 context) to {hit, key_index}.
package key_codes_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  // Extended (E0-prefixed) arrow codes
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  // Plain codes
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_Y     = 8'h35;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_H     = 8'h33;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_P     = 8'h4D;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_SEMI  = 8'h4C;
  localparam logic [7:0] SC_QUOTE = 8'h52;
  localparam logic [7:0] SC_SPACE = 8'h29;

  localparam logic [4:0] KI_UP    = 5'd0;
  localparam logic [4:0] KI_DOWN  = 5'd1;
  localparam logic [4:0] KI_LEFT  = 5'd2;
  localparam logic [4:0] KI_RIGHT = 5'd3;
  localparam logic [4:0] KI_W     = 5'd4;
  localparam logic [4:0] KI_A     = 5'd5;
  localparam logic [4:0] KI_S     = 5'd6;
  localparam logic [4:0] KI_D     = 5'd7;
  localparam logic [4:0] KI_Y     = 5'd8;
  localparam logic [4:0] KI_G     = 5'd9;
  localparam logic [4:0] KI_H     = 5'd10;
  localparam logic [4:0] KI_J     = 5'd11;
  localparam logic [4:0] KI_P     = 5'd12;
  localparam logic [4:0] KI_L     = 5'd13;
  localparam logic [4:0] KI_SEMI  = 5'd14;
  localparam logic [4:0] KI_QUOTE = 5'd15;
  localparam logic [4:0] KI_SPACE = 5'd16;

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_e;

  // Arrows only count with an E0 prefix; everything else only without it.
  function automatic logic [5:0] decode_key(input logic [7:0] code, input logic ext);
    logic [5:0] r;
    r = '0;
    if (ext) begin
      case (code)
        SC_UP:    r = {1'b1, KI_UP};
        SC_DOWN:  r = {1'b1, KI_DOWN};
        SC_LEFT:  r = {1'b1, KI_LEFT};
        SC_RIGHT: r = {1'b1, KI_RIGHT};
        default:  r = '0;
      endcase
    end else begin
      case (code)
        SC_W:     r = {1'b1, KI_W};
        SC_A:     r = {1'b1, KI_A};
        SC_S:     r = {1'b1, KI_S};
        SC_D:     r = {1'b1, KI_D};
        SC_Y:     r = {1'b1, KI_Y};
        SC_G:     r = {1'b1, KI_G};
        SC_H:     r = {1'b1, KI_H};
        SC_J:     r = {1'b1, KI_J};
        SC_P:     r = {1'b1, KI_P};
        SC_L:     r = {1'b1, KI_L};
        SC_SEMI:  r = {1'b1, KI_SEMI};
        SC_QUOTE: r = {1'b1, KI_QUOTE};
        SC_SPACE: r = {1'b1, KI_SPACE};
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Small synchronous FIFO for key events (push/pop/full/empty, head on dout).
// Latency: a pushed entry appears at dout the cycle after the push edge.
// Backpressure: push when full is dropped unless a pop happens in the same cycle.
module key_evt_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a simultaneous push into a full FIFO is kept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/key_event_arbiter.sv
// PS/2 byte parser -> held-key bitmap + per-player event FIFOs, round-robin output.
// Latency: KEYS_HELD/SPACE_PULSE one cycle after CODE_VALID; events visible the cycle after the write edge.
// Backpressure: EVT_VALID/EVT_READY handshake; grant and EVT_* frozen while stalled; full FIFO drops and sets OVERFLOW.
import key_codes_pkg::*;

module key_event_arbiter (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [7:0]  CODE_IN,
  input  logic        CODE_VALID,
  input  logic        CODE_ERR,
  output logic [16:0] KEYS_HELD,
  output logic        EVT_VALID,
  input  logic        EVT_READY,
  output logic        EVT_PLAYER,
  output logic [4:0]  EVT_KEY,
  output logic        EVT_MAKE,
  output logic        SPACE_PULSE,
  output logic        OVERFLOW
);

  parse_state_e state_q, state_d;
  logic [16:0]  held_q, held_d;
  logic         space_q, space_d;
  logic         ovf_q, ovf_d;
  logic         last_q, last_d;     // player of the last transfer (1 = P2)
  logic         grant_q, grant_d;
  logic         hold_q, hold_d;     // output was stalled last cycle: keep grant

  logic         byte_ok, is_prefix, is_break, key_vld, evt_fresh;
  logic [5:0]   dec;
  logic [4:0]   idx;
  logic         push_p1, push_p2, pop_p1, pop_p2;
  logic [5:0]   p1_dout, p2_dout, head;
  logic         p1_full, p1_empty, p2_full, p2_empty;
  logic         evt_vld, sel, xfer;

  assign byte_ok = CODE_VALID & ~RESET & ~CODE_ERR;

  // Parser FSM: state register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Parser FSM: next state
  always_comb begin
    state_d = state_q;
    if (CODE_VALID) begin
      if (CODE_ERR) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (CODE_IN == SC_E0)      state_d = ST_EXT;
            else if (CODE_IN == SC_F0) state_d = ST_BRK;
            else                       state_d = ST_IDLE;
          end
          ST_EXT:  state_d = (CODE_IN == SC_F0) ? ST_EXT_BRK : ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Parser FSM: decode outputs
  always_comb begin
    is_prefix = ((state_q == ST_IDLE) && ((CODE_IN == SC_E0) || (CODE_IN == SC_F0))) ||
                ((state_q == ST_EXT) && (CODE_IN == SC_F0));
    is_break  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    dec       = decode_key(CODE_IN, (state_q == ST_EXT) || (state_q == ST_EXT_BRK));
    idx       = dec[4:0];
    key_vld   = byte_ok & ~is_prefix & dec[5];
  end

  // Bitmap update; only edges of the held state become events (filters typematic repeat).
  always_comb begin
    held_d    = held_q;
    evt_fresh = 1'b0;
    if (key_vld) begin
      evt_fresh   = is_break ? held_q[idx] : ~held_q[idx];
      held_d[idx] = ~is_break;
    end
    space_d = evt_fresh & ~is_break & (idx == KI_SPACE);
    push_p1 = evt_fresh & (idx >= KI_W) & (idx <= KI_J);
    push_p2 = evt_fresh & ((idx <= KI_RIGHT) | ((idx >= KI_P) & (idx <= KI_QUOTE)));
  end

  key_evt_fifo #(.WIDTH(6), .DEPTH(FIFO_DEPTH)) u_fifo_p1 (
    .clk(CLOCK_50), .rst(RESET), .push(push_p1), .pop(pop_p1),
    .din({idx, ~is_break}), .dout(p1_dout), .full(p1_full), .empty(p1_empty)
  );

  key_evt_fifo #(.WIDTH(6), .DEPTH(FIFO_DEPTH)) u_fifo_p2 (
    .clk(CLOCK_50), .rst(RESET), .push(push_p2), .pop(pop_p2),
    .din({idx, ~is_break}), .dout(p2_dout), .full(p2_full), .empty(p2_empty)
  );

  // Round-robin grant, frozen while the consumer stalls so EVT_* never changes under it.
  always_comb begin
    evt_vld = ~p1_empty | ~p2_empty;
    if (hold_q)                    sel = grant_q;
    else if (~p1_empty & ~p2_empty) sel = ~last_q;
    else                           sel = ~p2_empty;
    xfer    = evt_vld & EVT_READY;
    pop_p1  = xfer & ~sel;
    pop_p2  = xfer & sel;
    grant_d = sel;
    hold_d  = evt_vld & ~EVT_READY;
    last_d  = xfer ? sel : last_q;
    ovf_d   = ovf_q | (push_p1 & p1_full & ~pop_p1) | (push_p2 & p2_full & ~pop_p2);
    head    = sel ? p2_dout : p1_dout;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      held_q  <= '0;
      space_q <= 1'b0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      held_q  <= held_d;
      space_q <= space_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  assign KEYS_HELD   = held_q;
  assign SPACE_PULSE = space_q;
  assign OVERFLOW    = ovf_q;
  assign EVT_VALID   = evt_vld;
  assign EVT_PLAYER  = evt_vld & sel;
  assign EVT_KEY     = evt_vld ? head[5:1] : 5'd0;
  assign EVT_MAKE    = evt_vld & head[0];

endmodule
